// File: rtl/demux_pkg.sv
// Shared constants and types for the buffered 1-to-2 stream demultiplexer.
package demux_pkg;

    localparam int unsigned DefaultWidth = 64;
    localparam int unsigned DefaultDepth = 2;

    typedef logic [DefaultWidth-1:0] word_t;

endpackage

// File: rtl/demux_1to2_buffered_if.sv
// Valid/ready bundle for the demux: one input stream, two output streams with occupancy.
interface demux_1to2_buffered_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic             in_select;
    logic [WIDTH-1:0] in_data;

    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic [CntW-1:0]  out0_count;

    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic [CntW-1:0]  out1_count;

    modport master (
        output in_valid, in_select, in_data, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out0_count,
        input  out1_valid, out1_data, out1_count
    );

    modport slave (
        input  in_valid, in_select, in_data, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out0_count,
        output out1_valid, out1_data, out1_count
    );

endinterface

// File: rtl/demux_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head data reads as zero while empty.
module demux_fifo
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth,
    localparam int unsigned PtrW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic             full_o,
    output logic [PtrW-1:0]  count_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int unsigned IdxW = PtrW - 1;

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             empty;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    // Same slot index but opposite lap means the writer is a full lap ahead.
    assign full_o  = (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]) &&
                     (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]);
    assign valid_o = ~empty;
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = empty ? '0 : mem_q[rd_ptr_q[IdxW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i && !full_o) begin
            mem_d[wr_ptr_q[IdxW-1:0]] = data_i;
            wr_ptr_d                  = wr_ptr_q + PtrW'(1);
        end
        if (pop_i && !empty) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/demux_1to2_buffered.sv
// Steers each accepted input word into one of two output FIFOs chosen by in_select.
module demux_1to2_buffered
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input logic                   clk,
    input logic                   reset,
    demux_1to2_buffered_if.slave  bus
);

    logic full0, full1;
    logic push0, push1;
    logic in_ready;

    // Only registered full flags feed in_ready, so consumer readies never reach it.
    assign in_ready     = ~(bus.in_select ? full1 : full0);
    assign bus.in_ready = in_ready;
    assign push0        = bus.in_valid & in_ready & ~bus.in_select;
    assign push1        = bus.in_valid & in_ready & bus.in_select;

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push0),
        .data_i  (bus.in_data),
        .pop_i   (bus.out0_ready),
        .valid_o (bus.out0_valid),
        .full_o  (full0),
        .count_o (bus.out0_count),
        .data_o  (bus.out0_data)
    );

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push1),
        .data_i  (bus.in_data),
        .pop_i   (bus.out1_ready),
        .valid_o (bus.out1_valid),
        .full_o  (full1),
        .count_o (bus.out1_count),
        .data_o  (bus.out1_data)
    );

endmodule

// File: tb/tb_demux_1to2_buffered.sv
// Directed bench for demux_1to2_buffered with per-output scoreboard queues.
module tb_demux_1to2_buffered;
    import demux_pkg::*;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned DEPTH = 2;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    word_t exp0_q[$];
    word_t exp1_q[$];

    demux_1to2_buffered_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    demux_1to2_buffered #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: inputs are stable from posedge+1, so at negedge the coming edge's
    // handshakes are already decided.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out0_valid && bus.out0_ready) begin
                if (exp0_q.size() == 0) chk("sb0_unexpected", bus.out0_data, 64'hdead);
                else chk("sb0_data", bus.out0_data, exp0_q.pop_front());
            end
            if (bus.out1_valid && bus.out1_ready) begin
                if (exp1_q.size() == 0) chk("sb1_unexpected", bus.out1_data, 64'hdead);
                else chk("sb1_data", bus.out1_data, exp1_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                if (bus.in_select) exp1_q.push_back(bus.in_data);
                else exp0_q.push_back(bus.in_data);
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_v0"}, 64'(bus.out0_valid), 64'd0);
        chk({tag, "_v1"}, 64'(bus.out1_valid), 64'd0);
        chk({tag, "_c0"}, 64'(bus.out0_count), 64'd0);
        chk({tag, "_c1"}, 64'(bus.out1_count), 64'd0);
        chk({tag, "_d0"}, bus.out0_data, 64'd0);
        chk({tag, "_d1"}, bus.out1_data, 64'd0);
        chk({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_select  = 1'b0;
        bus.in_data    = '0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        repeat (2) tick();
        chk_reset_state("por");
        reset = 1'b0;
        tick();

        // Route one word to each side with both consumers ready.
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_select  = 1'b0;
        bus.in_data    = 64'hA5;
        tick();
        chk("route_v0", 64'(bus.out0_valid), 64'd1);
        chk("route_d0", bus.out0_data, 64'hA5);
        bus.in_select = 1'b1;
        bus.in_data   = 64'h5A;
        tick();
        chk("route_v0_once", 64'(bus.out0_valid), 64'd0);
        chk("route_v1", 64'(bus.out1_valid), 64'd1);
        chk("route_d1", bus.out1_data, 64'h5A);
        bus.in_valid = 1'b0;
        tick();
        chk("route_v1_once", 64'(bus.out1_valid), 64'd0);

        // Fill out0, third word must stall; other side still accepts.
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_select  = 1'b0;
        bus.in_data    = 64'h1;
        tick();
        bus.in_data = 64'h2;
        tick();
        chk("fill_c0", 64'(bus.out0_count), 64'd2);
        bus.in_data = 64'h3;
        #1;
        chk("fill_rdy0", 64'(bus.in_ready), 64'd0);
        tick();
        chk("fill_c0_held", 64'(bus.out0_count), 64'd2);
        bus.in_select = 1'b1;
        #1;
        chk("fill_rdy1", 64'(bus.in_ready), 64'd1);
        tick();
        chk("fill_c1", 64'(bus.out1_count), 64'd1);
        chk("fill_d1", bus.out1_data, 64'h3);
        bus.in_valid = 1'b0;
        // A pop in flight must not raise in_ready for the full side.
        bus.in_select  = 1'b0;
        bus.out0_ready = 1'b1;
        #1;
        chk("fill_no_bypass", 64'(bus.in_ready), 64'd0);
        bus.out1_ready = 1'b1;
        repeat (3) tick();
        chk("fill_drained0", 64'(bus.out0_count), 64'd0);
        chk("fill_drained1", 64'(bus.out1_count), 64'd0);

        // Drain order with count walk-down.
        bus.out0_ready = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_select  = 1'b0;
        bus.in_data    = 64'h11;
        tick();
        bus.in_data = 64'h22;
        tick();
        bus.in_valid = 1'b0;
        chk("drain_c2", 64'(bus.out0_count), 64'd2);
        chk("drain_d11", bus.out0_data, 64'h11);
        bus.out0_ready = 1'b1;
        tick();
        chk("drain_c1", 64'(bus.out0_count), 64'd1);
        chk("drain_d22", bus.out0_data, 64'h22);
        tick();
        chk("drain_c0", 64'(bus.out0_count), 64'd0);
        chk("drain_v0", 64'(bus.out0_valid), 64'd0);
        chk("drain_d0", bus.out0_data, 64'd0);

        // Concurrent push/pop on out1 across pointer wrap.
        bus.out1_ready = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_select  = 1'b1;
        bus.in_data    = 64'h100;
        tick();
        chk("conc_c1_start", 64'(bus.out1_count), 64'd1);
        bus.out1_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_data = 64'h200 + 64'(i);
            tick();
            chk("conc_c1", 64'(bus.out1_count), 64'd1);
            chk("conc_d1", bus.out1_data, 64'h200 + 64'(i));
        end
        bus.in_valid = 1'b0;
        tick();
        chk("conc_c1_end", 64'(bus.out1_count), 64'd0);

        // Reset during traffic with both FIFOs full.
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        bus.in_valid   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_select = i[1];
            bus.in_data   = 64'hC0 + 64'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("rst_full_c0", 64'(bus.out0_count), 64'd2);
        chk("rst_full_c1", 64'(bus.out1_count), 64'd2);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("midrst");
        exp0_q.delete();
        exp1_q.delete();
        tick();
        reset          = 1'b0;
        bus.out1_ready = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_select  = 1'b1;
        bus.in_data    = 64'hBEEF;
        tick();
        bus.in_valid = 1'b0;
        chk("post_c1", 64'(bus.out1_count), 64'd1);
        chk("post_d1", bus.out1_data, 64'hBEEF);
        chk("post_v0", 64'(bus.out0_valid), 64'd0);
        tick();
        chk("post_v1", 64'(bus.out1_valid), 64'd0);
        tick();

        chk("sb0_left", 64'(exp0_q.size()), 64'd0);
        chk("sb1_left", 64'(exp1_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
